// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned PARITY_EVEN = 0;
  localparam int unsigned PARITY_ODD  = 1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line and parity enable in, byte and flags out.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rx_in;
  logic                  parity_en;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic                  busy;

  // master: the receiver itself; slave: the logic feeding the line and consuming bytes
  modport master (
    input  rx_in,
    input  parity_en,
    output p_data,
    output data_valid,
    output parity_error,
    output stop_error,
    output busy
  );

  modport slave (
    output rx_in,
    output parity_en,
    input  p_data,
    input  data_valid,
    input  parity_error,
    input  stop_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timer and 3-sample majority voter around the middle of each bit period.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic rxs_i,
  output logic vote_o,
  output logic sample_done_o,
  output logic bit_end_o
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned Mid  = PRESCALE / 2;

  localparam logic [CntW-1:0] SampA  = CntW'(Mid - 1);
  localparam logic [CntW-1:0] SampB  = CntW'(Mid);
  localparam logic [CntW-1:0] SampC  = CntW'(Mid + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s0_q, s0_d;
  logic            s1_q, s1_d;

  // Counter parks at 0 while idle so a new frame always starts at cnt = 0
  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    if (!run_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SampA) s0_d = rxs_i;
      if (cnt_q == SampB) s1_d = rxs_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

  assign vote_o        = majority3(s0_q, s1_q, rxs_i);
  assign sample_done_o = run_i && (cnt_q == SampC);
  assign bit_end_o     = run_i && (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_in, deframes start/data/parity/stop and flags frame errors.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE    = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_TYPE = PARITY_EVEN
) (
  input logic        clk,
  input logic        rst,
  uart_rx_if.master  uart_io
);

  localparam int unsigned IdxW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_WIDTH - 1);
  localparam logic ParOdd = (PARITY_TYPE == PARITY_ODD);

  rx_state_e             state_q, state_d;
  logic [IdxW-1:0]       bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  pen_q, pen_d;
  logic                  par_q, par_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  rx_meta_q, rxs_q;

  logic vote, sample_done, bit_end;
  logic exp_par, stop_bad, par_bad;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_io.rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .run_i         (state_q != StIdle),
    .rxs_i         (rxs_q),
    .vote_o        (vote),
    .sample_done_o (sample_done),
    .bit_end_o     (bit_end)
  );

  assign exp_par  = ParOdd ? ~^shift_q : ^shift_q;
  assign stop_bad = ~vote;
  assign par_bad  = pen_q & (par_q != exp_par);

  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    p_data_d = p_data_q;
    pen_d    = pen_q;
    par_d    = par_q;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    se_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          pen_d   = uart_io.parity_en;
        end
      end
      StStart: begin
        if (sample_done && vote) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
          bidx_d  = '0;
        end
      end
      StData: begin
        if (sample_done) shift_d[bidx_q] = vote;
        if (bit_end) begin
          if (bidx_q == IdxMax) begin
            state_d = pen_q ? StParity : StStop;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (sample_done) par_d = vote;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
        if (sample_done) begin
          se_d    = stop_bad;
          pe_d    = par_bad;
          state_d = StIdle;
          if (!stop_bad && !par_bad) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bidx_q   <= '0;
      shift_q  <= '0;
      p_data_q <= '0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      p_data_q <= p_data_d;
      pen_q    <= pen_d;
      par_q    <= par_d;
      dv_q     <= dv_d;
      pe_q     <= pe_d;
      se_q     <= se_d;
    end
  end

  assign uart_io.p_data       = p_data_q;
  assign uart_io.data_valid   = dv_q;
  assign uart_io.parity_error = pe_q;
  assign uart_io.stop_error   = se_q;
  assign uart_io.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames, scoreboards expected pulses against observed ones.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          dv;
    logic          pe;
    logic          se;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW)) u_if ();

  uart_rx #(
    .PRESCALE    (P),
    .DATA_WIDTH  (DW),
    .PARITY_TYPE (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_io (u_if)
  );

  res_t          exp_q[$];
  res_t          obs_q[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] last_good = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse together with its cycle stamp
  always @(negedge clk) begin
    if (!rst && (u_if.data_valid || u_if.parity_error || u_if.stop_error)) begin
      obs_q.push_back({u_if.p_data, u_if.data_valid, u_if.parity_error, u_if.stop_error});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    @(posedge clk); #1;
    u_if.rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits in transmit order; returns the bit count
  function automatic int build(input logic [DW-1:0] d, input logic pen, input logic par,
                               input logic stop, output logic [DW+2:0] bits);
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    n = DW + 1;
    if (pen) begin
      bits[n] = par;
      n++;
    end
    bits[n] = stop;
    return n + 1;
  endfunction

  // glitch_bit >= 0 inverts one cycle at the voter's middle sample of that frame bit
  task automatic drive_frame(input logic [DW-1:0] d, input logic pen, input logic par,
                             input logic stop, input int max_bits, input int glitch_bit);
    logic [DW+2:0] bits;
    int            n;
    n = build(d, pen, par, stop, bits);
    if (max_bits < n) n = max_bits;
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < P; j++) begin
        @(posedge clk); #1;
        u_if.rx_in = (b == glitch_bit && j == P / 2 + 1) ? ~bits[b] : bits[b];
      end
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int budget;
    budget = 400;
    while (obs_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (obs_q.size() >= n);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_obs: got %0d pulses, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    res_t o, e;
    bit   ok;
    u_if.rx_in     = 1'b1;
    u_if.parity_en = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({u_if.p_data, u_if.data_valid, u_if.parity_error, u_if.stop_error, u_if.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h required 0", {u_if.p_data, u_if.busy});
    end
    #1 rst = 1'b0;
    idle(4);
    exp_q.push_back({8'h96, 3'b100});
    drive_frame(8'h96, 1'b0, 1'b0, 1'b1, 99, -1);
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL pre_reset_frame: got %h required %h", o, e); end
    end
    idle(4);
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b1, 4, -1);
    @(negedge clk);
    n_cmp++;
    if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid_data: got %b required 1", u_if.busy); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({u_if.p_data, u_if.data_valid, u_if.parity_error, u_if.stop_error, u_if.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_data: got %h busy %b required all 0", u_if.p_data, u_if.busy);
    end
    u_if.rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(40);
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_no_pulse: got %0d pulses required 0", obs_q.size()); end
    exp_q.push_back({8'h3C, 3'b100});
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b1, 99, -1);
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL post_reset_frame: got %h required %h", o, e); end
    end
    last_good = 8'h3C;
    idle(4);
  endtask

  task automatic test_parity();
    res_t o, e;
    bit   ok;
    u_if.parity_en = 1'b1;
    exp_q.push_back({8'hA5, 3'b100});
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b1, 99, -1);
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL parity_good: got %h required %h", o, e); end
    end
    last_good = 8'hA5;
    idle(4);
    exp_q.push_back({last_good, 3'b010});
    drive_frame(8'hA5, 1'b1, 1'b1, 1'b1, 99, -1);
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL parity_bad: got %h required %h", o, e); end
    end
    idle(4);
    n_cmp++;
    if (u_if.p_data !== last_good) begin
      n_bad++; $display("FAIL parity_hold: got %h required %h", u_if.p_data, last_good);
    end
    u_if.parity_en = 1'b0;
  endtask

  task automatic test_stop_error();
    res_t o, e;
    bit   ok;
    exp_q.push_back({last_good, 3'b001});
    drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 99, -1);
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL stop_error: got %h required %h", o, e); end
    end
    idle(40);
    n_cmp++;
    if (obs_q.size() != 0 || u_if.p_data !== last_good || u_if.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_error_after: got pulses %0d p_data %h busy %b required 0 %h 0",
               obs_q.size(), u_if.p_data, u_if.busy, last_good);
    end
  endtask

  task automatic test_glitch();
    res_t o, e;
    bit   ok;
    @(posedge clk); #1 u_if.rx_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 u_if.rx_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start: got busy %b required 1", u_if.busy); end
    idle(20);
    n_cmp++;
    if (u_if.busy !== 1'b0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL glitch_reject: got busy %b pulses %0d required 0 0", u_if.busy, obs_q.size());
    end
    exp_q.push_back({8'h6B, 3'b100});
    drive_frame(8'h6B, 1'b0, 1'b0, 1'b1, 99, 4);
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL glitch_vote: got %h required %h", o, e); end
    end
    last_good = 8'h6B;
    idle(4);
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    bit   ok;
    int   c0, c1;
    exp_q.push_back({8'h55, 3'b100});
    exp_q.push_back({8'hAA, 3'b100});
    drive_frame(8'h55, 1'b0, 1'b0, 1'b1, 99, -1);
    drive_frame(8'hAA, 1'b0, 1'b0, 1'b1, 99, -1);
    wait_obs(2, ok);
    if (ok) begin
      o = obs_q.pop_front(); c0 = obs_cyc.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_first: got %h required %h", o, e); end
      o = obs_q.pop_front(); c1 = obs_cyc.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_second: got %h required %h", o, e); end
      n_cmp++;
      if (c1 - c0 != 10 * P) begin
        n_bad++; $display("FAIL b2b_spacing: got %0d cycles required %0d", c1 - c0, 10 * P);
      end
    end
    last_good = 8'hAA;
    idle(4);
  endtask

  task automatic test_pen_toggle();
    res_t o, e;
    bit   ok;
    // Good parity, parity_en flapping during DATA
    u_if.parity_en = 1'b1;
    exp_q.push_back({8'h0F, 3'b100});
    fork
      drive_frame(8'h0F, 1'b1, 1'b0, 1'b1, 99, -1);
      begin
        repeat (20) @(posedge clk);
        #2 u_if.parity_en = 1'b0;
        repeat (20) @(posedge clk);
        #2 u_if.parity_en = 1'b1;
        repeat (10) @(posedge clk);
        #2 u_if.parity_en = 1'b0;
      end
    join
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL pen_toggle_good: got %h required %h", o, e); end
    end
    last_good = 8'h0F;
    idle(4);
    // Bad parity, parity_en dropped once DATA has begun
    u_if.parity_en = 1'b1;
    exp_q.push_back({last_good, 3'b010});
    fork
      drive_frame(8'h0E, 1'b1, 1'b0, 1'b1, 99, -1);
      begin
        repeat (16) @(posedge clk);
        #2 u_if.parity_en = 1'b0;
      end
    join
    wait_obs(1, ok);
    if (ok) begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL pen_toggle_bad: got %h required %h", o, e); end
    end
    idle(20);
  endtask

  initial begin
    u_if.rx_in     = 1'b1;
    u_if.parity_en = 1'b0;
    test_reset();
    test_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_pen_toggle();
    n_cmp++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d observed %0d expected entries required 0 0",
               obs_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
